cache_req_arbiter: RTL and testbench

- Shares the single CPU-side port of cache_top between NUM_REQ requesters, e.g. instruction fetch (req 0) and load/store unit (req 1).
- Round-robin arbitration; latches the winner's command and drives the cache request/ready handshake to completion.
- Inserts a one-cycle release gap between transactions, returns data and ready to the granted requester, and keeps a contention counter for performance debug.

---
 rtl/cache_arb_pkg.sv | 15 +
 rtl/cache_req_arbiter_rr_picker.sv | 27 ++
 rtl/cache_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_cache_req_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the cache request arbiter and its helpers.
package cache_arb_pkg;

    // Arbiter FSM: wait for a request, run one cache transaction, hold one idle cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 16;

endpackage

// File: rtl/cache_req_arbiter_rr_picker.sv
// Rotating priority encoder: the first requester after i_last (wrapping) wins.
// Purely combinational so it can sit in front of any shared-port FSM.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_valid
);

    // Scan N positions starting one past the previous winner; keep the first hit.
    always_comb begin
        o_winner = i_last;
        o_valid  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(i_last) + k) % N;
            if (!o_valid && i_req[idx]) begin
                o_winner = IDX_W'(idx);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing the single CPU-side cache port between NUM_REQ requesters.
// Handshake: a requester raises req_req with its fields and holds them until its
// one-cycle req_ready pulse; the winner's fields are latched at the grant edge and
// cache_req stays high (fields stable) until cache_ready is sampled high.
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter int STRB_W  = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      cache_req,
    output logic                      cache_we,
    output logic [ADDR_W-1:0]         cache_addr,
    output logic [DATA_W-1:0]         cache_wdata,
    output logic [STRB_W-1:0]         cache_wstrb,
    input  logic                      cache_ready,
    input  logic [DATA_W-1:0]         cache_rdata,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          contention_cnt,
    output logic [1:0]                dbg_state
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  r_grant;
    logic [IDX_W-1:0]  w_winner;
    logic              w_valid;
    logic              w_grant_fire;
    logic              w_done_fire;
    logic              w_contended;
    int                w_pend_cnt;
    logic              r_cache_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [CNT_W-1:0]  r_cnt;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req    (req_req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Number of requesters pending this cycle, used to flag contended grants.
    always_comb begin
        w_pend_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pend_cnt = w_pend_cnt + int'(req_req[i]);
        end
    end

    assign w_contended = (w_pend_cnt >= 2);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; requests are only looked at in IDLE, so RELEASE forces a gap.
    always_comb begin
        w_next_state = r_state;
        w_grant_fire = 1'b0;
        w_done_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next_state = BUSY;
                    w_grant_fire = 1'b1;
                end
            end
            BUSY: begin
                if (cache_ready) begin
                    w_next_state = RELEASE;
                    w_done_fire  = 1'b1;
                end
            end
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the winner's command at the grant edge and drop the cache request on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_req <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_grant     <= '0;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_cnt       <= '0;
        end else if (w_grant_fire) begin
            r_cache_req <= 1'b1;
            r_we        <= req_we[w_winner];
            r_addr      <= req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
            r_wdata     <= req_wdata[int'(w_winner)*DATA_W +: DATA_W];
            r_wstrb     <= req_wstrb[int'(w_winner)*STRB_W +: STRB_W];
            r_grant     <= w_winner;
            r_last      <= w_winner;
            if (w_contended && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_done_fire) begin
            r_cache_req <= 1'b0;
        end
    end

    // Completion pulse goes only to the granted requester, and only while BUSY.
    always_comb begin
        req_ready = '0;
        if ((r_state == BUSY) && cache_ready) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    assign req_rdata      = cache_rdata;
    assign cache_req      = r_cache_req;
    assign cache_we       = r_we;
    assign cache_addr     = r_addr;
    assign cache_wdata    = r_wdata;
    assign cache_wstrb    = r_wstrb;
    assign grant_id       = r_grant;
    assign busy           = (r_state == BUSY);
    assign contention_cnt = r_cnt;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: two requesters, a behavioural cache responder and a
// port-occupancy reference model that predicts grants, latched fields and ready pulses.
module tb_cache_req_arbiter;
  import cache_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic            cache_req, cache_we, cache_ready = 1'b0;
  logic [AW-1:0]   cache_addr;
  logic [DW-1:0]   cache_wdata, cache_rdata = '0;
  logic [SW-1:0]   cache_wstrb;
  logic [0:0]      grant_id;
  logic            busy;
  logic [15:0]     contention_cnt;
  logic [1:0]      dbg_state;

  cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_req(req_req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready), .req_rdata(req_rdata),
    .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_wstrb(cache_wstrb), .cache_ready(cache_ready),
    .cache_rdata(cache_rdata), .grant_id(grant_id), .busy(busy),
    .contention_cnt(contention_cnt), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- requesters ----------------
  txn_t          txq [N][$];
  bit            active [N];
  bit            done_seen [N];
  int            done_cnt [N];
  int            present_cyc [N];
  logic [DW-1:0] last_rdata [N];
  bit            scramble = 0;
  bit            jitter = 0;

  // ---------------- cache responder ----------------
  logic [DW-1:0] cache_mem [logic [AW-1:0]];
  logic [DW-1:0] gold_mem [logic [AW-1:0]];
  bit stall = 0;
  bit spurious = 0;
  int min_wait = 0;
  int resp_wait = -1;

  // ---------------- reference model ----------------
  int            m_phase;   // 0 port free, 1 port owned, 2 release gap
  int            m_owner, m_last, m_cnt;
  txn_t          m_fields;
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  p_req;
  txn_t          p_fields [N];
  logic          p_ready, p_rst;

  // observation logs
  int   grant_log[$], cnt_log[$], gap_log[$], rel_log[$], lat_log[$];
  logic [SW-1:0] strb_log[$];
  logic prev_creq = 1'b0;
  int   fall_cyc = -1;
  int   rel_run = 0;

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [SW-1:0] s);
    logic [DW-1:0] r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] cache_read(logic [AW-1:0] a);
    return cache_mem.exists(a) ? cache_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] gold_read(logic [AW-1:0] a);
    return gold_mem.exists(a) ? gold_mem[a] : init_word(a);
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic txn_t mk(logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.wstrb = s;
    return t;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (txq[i].size() > 0 || active[i]) return 1;
    return 0;
  endfunction

  // One clock: capture inputs seen at the edge, advance the model, compare, drive, check ready.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    arb_state_t   exp_st;
    int           w;
    p_req = req_req; p_ready = cache_ready; p_rst = rst;
    for (int i = 0; i < N; i++)
      p_fields[i] = mk(req_we[i], req_addr[i*AW +: AW], req_wdata[i*DW +: DW], req_wstrb[i*SW +: SW]);
    @(negedge clk);
    cyc++;
    // model: what the edge just passed should have done
    if (p_rst) begin
      m_phase = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
      m_fields = mk(1'b0, '0, '0, '0);
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (p_req != '0) begin
          w = rr_pick(p_req, m_last);
          m_last = w; m_owner = w; m_fields = p_fields[w]; m_phase = 1;
          if ($countones(p_req) >= 2 && m_cnt < 65535) m_cnt++;
          grant_log.push_back(w); cnt_log.push_back(m_cnt);
          if (!m_fields.we) exp_q.push_back(gold_read(m_fields.addr));
        end
        1: if (p_ready) begin
          m_phase = 2;
          if (m_fields.we)
            gold_mem[m_fields.addr] = merge(gold_read(m_fields.addr), m_fields.wdata, m_fields.wstrb);
        end
        default: m_phase = 0;
      endcase
    end
    exp_st = (m_phase == 1) ? BUSY : (m_phase == 2) ? RELEASE : IDLE;
    checks += 6;
    if (cache_req !== (m_phase == 1)) begin errors++; $display("FAIL cache_req: got %b want %b cyc %0d", cache_req, m_phase == 1, cyc); end
    if (busy !== (m_phase == 1)) begin errors++; $display("FAIL busy: got %b want %b cyc %0d", busy, m_phase == 1, cyc); end
    if (dbg_state !== exp_st) begin errors++; $display("FAIL state: got %0d want %0d cyc %0d", dbg_state, exp_st, cyc); end
    if (grant_id !== 1'(m_owner)) begin errors++; $display("FAIL grant_id: got %0d want %0d cyc %0d", grant_id, m_owner, cyc); end
    if (contention_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL contention: got %0d want %0d cyc %0d", contention_cnt, m_cnt, cyc); end
    if (cache_we !== m_fields.we || cache_addr !== m_fields.addr || cache_wdata !== m_fields.wdata || cache_wstrb !== m_fields.wstrb) begin
      errors++;
      $display("FAIL cache_fields: got we=%b a=%h d=%h s=%h want we=%b a=%h d=%h s=%h cyc %0d", cache_we, cache_addr, cache_wdata, cache_wstrb,
               m_fields.we, m_fields.addr, m_fields.wdata, m_fields.wstrb, cyc);
    end
    // observation logs for gap / release / latency checks
    if (cache_req === 1'b1 && !prev_creq) begin
      if (fall_cyc >= 0) gap_log.push_back(cyc - fall_cyc);
      lat_log.push_back(cyc - present_cyc[int'(grant_id)]);
      strb_log.push_back(cache_wstrb);
    end
    if (cache_req === 1'b0 && prev_creq) fall_cyc = cyc;
    prev_creq = (cache_req === 1'b1);
    if (dbg_state === RELEASE) rel_run++;
    else if (rel_run > 0) begin rel_log.push_back(rel_run); rel_run = 0; end
    // requesters
    for (int i = 0; i < N; i++) begin
      if (active[i] && done_seen[i]) begin
        active[i] = 0; done_seen[i] = 0; req_req[i] = 1'b0;
      end else if (!active[i] && txq[i].size() > 0 && !rst && (!jitter || $urandom_range(0, 2) != 0)) begin
        txn_t t = txq[i].pop_front();
        active[i] = 1; present_cyc[i] = cyc; req_req[i] = 1'b1;
        req_we[i] = t.we; req_addr[i*AW +: AW] = t.addr;
        req_wdata[i*DW +: DW] = t.wdata; req_wstrb[i*SW +: SW] = t.wstrb;
      end else if (active[i] && scramble && m_phase == 1 && m_owner == i) begin
        req_we[i] = 1'($urandom); req_addr[i*AW +: AW] = $urandom;
        req_wdata[i*DW +: DW] = $urandom; req_wstrb[i*SW +: SW] = 4'($urandom);
      end
    end
    // cache responder
    if (rst) begin
      cache_ready = 1'b0; resp_wait = -1;
    end else if (spurious) begin
      cache_ready = 1'b1; cache_rdata = $urandom;
    end else begin
      cache_ready = 1'b0;
      if (cache_req === 1'b1 && !stall) begin
        if (resp_wait < 0) resp_wait = $urandom_range(min_wait, min_wait + 2);
        if (resp_wait == 0) begin
          cache_ready = 1'b1; resp_wait = -1;
          if (cache_we) begin
            cache_mem[cache_addr] = merge(cache_read(cache_addr), cache_wdata, cache_wstrb);
            cache_rdata = $urandom;
          end else begin
            cache_rdata = cache_read(cache_addr);
          end
        end else begin
          resp_wait--;
        end
      end else if (cache_req !== 1'b1) begin
        resp_wait = -1;
      end
    end
    #1;
    exp_rdy = (m_phase == 1 && cache_ready) ? N'(1 << m_owner) : '0;
    checks++;
    if (req_ready !== exp_rdy) begin errors++; $display("FAIL req_ready: got %b want %b cyc %0d", req_ready, exp_rdy, cyc); end
    if (exp_rdy != '0) begin
      checks++;
      if (req_rdata !== cache_rdata) begin errors++; $display("FAIL rdata_pass: got %h want %h", req_rdata, cache_rdata); end
      if (!m_fields.we) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL read_q: no expected read data"); end
        else begin
          logic [DW-1:0] e = exp_q.pop_front();
          if (req_rdata !== e) begin errors++; $display("FAIL read_data: got %h want %h addr %h", req_rdata, e, m_fields.addr); end
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1 && active[i]) begin done_seen[i] = 1; done_cnt[i]++; last_rdata[i] = req_rdata; end
  endtask

  task automatic run(input int budget, input string tag);
    int n = 0;
    do begin cycle(); n++; end while ((pending() || m_phase != 0) && n < budget);
    checks++;
    if (n >= budget) begin errors++; $display("FAIL %s_timeout: still busy after %0d cycles", tag, n); end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_req = '0; stall = 0; spurious = 0; scramble = 0; jitter = 0; min_wait = 0;
    for (int i = 0; i < N; i++) begin txq[i].delete(); active[i] = 0; done_seen[i] = 0; done_cnt[i] = 0; end
    cycle(); cycle();
    rst = 1'b0;
    grant_log.delete(); cnt_log.delete(); gap_log.delete(); rel_log.delete(); lat_log.delete(); strb_log.delete();
    fall_cyc = -1; rel_run = 0;
    cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    checks += 4;
    if (cache_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl: req=%b busy=%b want 0 0", cache_req, busy); end
    if (grant_id !== 1'b0 || contention_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: gid=%0d cnt=%0d want 0 0", grant_id, contention_cnt); end
    if (cache_addr !== '0 || cache_wdata !== '0 || cache_wstrb !== '0 || cache_we !== 1'b0) begin errors++; $display("FAIL reset_fields: a=%h d=%h s=%h we=%b want all 0", cache_addr, cache_wdata, cache_wstrb, cache_we); end
    if (req_ready !== '0 || dbg_state !== IDLE) begin errors++; $display("FAIL reset_ready_state: rdy=%b st=%0d want 0 0", req_ready, dbg_state); end
    do_reset();
  endtask

  task automatic test_single_read();
    logic [DW-1:0] e;
    do_reset();
    e = gold_read(32'h0);
    txq[0].push_back(mk(1'b0, 32'h0000_0000, '0, '0));
    run(100, "single");
    checks += 4;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin errors++; $display("FAIL single_grant: got %0d grants want one to req0", grant_log.size()); end
    if (lat_log.size() < 1 || lat_log[0] != 1) begin errors++; $display("FAIL single_latency: got %0d want 1", lat_log.size() ? lat_log[0] : -1); end
    if (done_cnt[0] != 1 || done_cnt[1] != 0) begin errors++; $display("FAIL single_pulses: got %0d/%0d want 1/0", done_cnt[0], done_cnt[1]); end
    if (last_rdata[0] !== e) begin errors++; $display("FAIL single_data: got %h want %h", last_rdata[0], e); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    txq[0].push_back(mk(1'b0, 32'h0000_0000, '0, '0));
    txq[1].push_back(mk(1'b1, 32'h0000_2000, 32'h1111_AAAA, 4'hF));
    run(200, "simul");
    txq[0].push_back(mk(1'b0, 32'h0000_2000, '0, '0));
    run(200, "simul_rd");
    checks += 5;
    if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0) begin errors++; $display("FAIL simul_order: got %0d grants want 0,1,0", grant_log.size()); end
    if (gap_log.size() < 1 || gap_log[0] != 2) begin errors++; $display("FAIL simul_gap: got %0d want 2", gap_log.size() ? gap_log[0] : -1); end
    if (strb_log.size() < 2 || strb_log[1] !== 4'hF) begin errors++; $display("FAIL simul_wstrb: got %h want f", strb_log.size() > 1 ? strb_log[1] : 4'h0); end
    if (contention_cnt !== 16'd1) begin errors++; $display("FAIL simul_contention: got %0d want 1", contention_cnt); end
    if (last_rdata[0] !== 32'h1111_AAAA) begin errors++; $display("FAIL simul_readback: got %h want 1111aaaa", last_rdata[0]); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++)
        txq[i].push_back(mk(1'($urandom), 32'h100 + 32'($urandom_range(0, 7)) * 4, $urandom, 4'($urandom)));
    run(400, "fair");
    checks += 4;
    for (int g = 0; g < 6; g++)
      if (g >= grant_log.size() || grant_log[g] != g % 2) begin errors++; $display("FAIL fair_order: grant %0d got %0d want %0d", g, g < grant_log.size() ? grant_log[g] : -1, g % 2); break; end
    if (cnt_log.size() < 6 || cnt_log[5] != 6) begin errors++; $display("FAIL fair_contention: got %0d want 6", cnt_log.size() > 5 ? cnt_log[5] : -1); end
    for (int g = 0; g < 5; g++)
      if (g >= gap_log.size() || gap_log[g] != 2) begin errors++; $display("FAIL fair_gap: gap %0d got %0d want 2", g, g < gap_log.size() ? gap_log[g] : -1); break; end
    foreach (rel_log[g])
      if (rel_log[g] != 1) begin errors++; $display("FAIL fair_release: run %0d got %0d cycles want 1", g, rel_log[g]); break; end
  endtask

  task automatic test_latched_fields();
    int n = 0;
    do_reset();
    scramble = 1; min_wait = 3;
    txq[1].push_back(mk(1'b1, 32'h0000_4000, 32'h3333_CCCC, 4'hF));
    do begin
      cycle(); n++;
      if (busy === 1'b1) begin
        checks++;
        if (cache_addr !== 32'h0000_4000 || cache_wdata !== 32'h3333_CCCC) begin errors++; $display("FAIL latched: got %h/%h want 00004000/3333cccc", cache_addr, cache_wdata); end
      end
    end while ((pending() || m_phase != 0) && n < 100);
    scramble = 0; min_wait = 0;
    txq[0].push_back(mk(1'b0, 32'h0000_4000, '0, '0));
    run(100, "latched_rd");
    checks++;
    if (last_rdata[0] !== 32'h3333_CCCC) begin errors++; $display("FAIL latched_readback: got %h want 3333cccc", last_rdata[0]); end
  endtask

  task automatic test_reset_mid_op();
    logic [DW-1:0] e;
    do_reset();
    stall = 1;
    txq[0].push_back(mk(1'b0, 32'h0000_0000, '0, '0));
    txq[1].push_back(mk(1'b0, 32'h0000_0040, '0, '0));
    repeat (4) cycle();
    checks++;
    if (busy !== 1'b1 || contention_cnt !== 16'd1) begin errors++; $display("FAIL midop_pre: busy=%b cnt=%0d want 1 1", busy, contention_cnt); end
    rst = 1'b1; req_req = '0;
    for (int i = 0; i < N; i++) begin txq[i].delete(); active[i] = 0; done_seen[i] = 0; end
    cycle();
    checks++;
    if (cache_req !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || contention_cnt !== 16'd0) begin
      errors++; $display("FAIL midop_reset: req=%b busy=%b rdy=%b cnt=%0d want 0 0 0 0", cache_req, busy, req_ready, contention_cnt);
    end
    rst = 1'b0; stall = 0; done_cnt[1] = 0; grant_log.delete();
    e = gold_read(32'h0);
    txq[1].push_back(mk(1'b0, 32'h0000_0000, '0, '0));
    run(100, "midop_after");
    checks++;
    if (done_cnt[1] != 1 || last_rdata[1] !== e || grant_log.size() != 1 || grant_log[0] != 1) begin
      errors++; $display("FAIL midop_after: pulses=%0d data=%h want 1 %h", done_cnt[1], last_rdata[1], e);
    end
  endtask

  task automatic test_spurious_ready();
    do_reset();
    spurious = 1;
    repeat (4) begin
      cycle();
      checks++;
      if (req_ready !== '0 || dbg_state !== IDLE || busy !== 1'b0) begin errors++; $display("FAIL spurious: rdy=%b st=%0d busy=%b want 0 0 0", req_ready, dbg_state, busy); end
    end
    spurious = 0;
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    jitter = 1;
    for (int k = 0; k < 30; k++)
      for (int i = 0; i < N; i++)
        txq[i].push_back(mk(1'($urandom), 32'h800 + 32'($urandom_range(0, 7)) * 4, $urandom, 4'($urandom)));
    scramble = 1;
    run(3000, "random");
    checks += 2;
    if (done_cnt[0] != 30 || done_cnt[1] != 30) begin errors++; $display("FAIL random_done: got %0d/%0d want 30/30", done_cnt[0], done_cnt[1]); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_reads_left: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_latched_fields();
    test_reset_mid_op();
    test_spurious_ready();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish after %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
